// File: rtl/arbiter_puf_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation engine.
package arbiter_puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StSample,
        StRelax,
        StDone
    } state_e;

    // Width able to hold values 0..n inclusive, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arbiter_chain.sv
// Behavioural arbiter delay chain: challenge-controlled crossed/straight stages plus
// the arbiter latch, modelled with per-instance stage delay differences.
module arbiter_chain #(
    parameter int unsigned N_STAGES = 16,
    parameter int unsigned INST     = 0
) (
    input  logic                pulse,
    input  logic [N_STAGES-1:0] challenge,
    output logic                result
);

    // Signed delay difference contributed by stage k; varies per instance.
    function automatic int stage_weight(input int unsigned k);
        return int'((INST * 37 + k * 11 + 3) % 9) - 4;
    endfunction

    int   acc;
    logic par;

    // A crossed stage flips the sign of every delay difference upstream of it, so each
    // stage term is weighted by the challenge parity from that stage to the arbiter.
    always_comb begin
        acc = 0;
        par = 1'b0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            par = par ^ challenge[k];
            acc = par ? (acc - stage_weight(k)) : (acc + stage_weight(k));
        end
        // With no edge launched both paths sit low and the latch reads zero.
        result = pulse & (acc > 0);
    end

endmodule

// File: rtl/arbiter_puf_tmv.sv
// Arbiter-PUF engine: N_RESP chains evaluated N_EVAL times per challenge, per-bit
// temporal majority vote with instability flags, valid/ready on both sides.
module arbiter_puf_tmv
    import arbiter_puf_pkg::*;
#(
    parameter int unsigned N_STAGES   = 16,
    parameter int unsigned N_RESP     = 16,
    parameter int unsigned N_EVAL     = 7,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_STAGES-1:0] challenge,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N_RESP-1:0]   response,
    output logic [N_RESP-1:0]   unstable,
    output logic                busy
);

    localparam int unsigned EW = cnt_width(N_EVAL);
    localparam int unsigned SW = cnt_width(SETTLE_CYC);

    localparam logic [EW-1:0] EvalTotal  = EW'(N_EVAL);
    localparam logic [EW-1:0] EvalHalf   = EW'(N_EVAL / 2);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);

    if (N_EVAL % 2 == 0) begin : g_bad_eval
        $error("arbiter_puf_tmv: N_EVAL must be odd");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("arbiter_puf_tmv: SETTLE_CYC must be at least 1");
    end
    if (N_STAGES < 1) begin : g_bad_stages
        $error("arbiter_puf_tmv: N_STAGES must be at least 1");
    end

    state_e              state_q, state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [EW-1:0]       eval_q, eval_d;
    logic [EW-1:0]       vote_q [N_RESP];
    logic [EW-1:0]       vote_d [N_RESP];
    logic [N_STAGES-1:0] challenge_q, challenge_d;
    logic [N_RESP-1:0]   response_q, response_d;
    logic [N_RESP-1:0]   unstable_q, unstable_d;
    logic                pulse, pulse_d;

    logic [N_RESP-1:0]   chain_out;
    logic [N_RESP-1:0]   arb_raw;

    for (genvar g = 0; g < N_RESP; g++) begin : g_chain
        arbiter_chain #(
            .N_STAGES (N_STAGES),
            .INST     (g)
        ) u_chain (
            .pulse     (pulse),
            .challenge (challenge_q),
            .result    (chain_out[g])
        );
    end

    assign arb_raw = chain_out;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        eval_d      = eval_q;
        vote_d      = vote_q;
        challenge_d = challenge_q;
        response_d  = response_q;
        unstable_d  = unstable_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    challenge_d = challenge;
                    eval_d      = '0;
                    settle_d    = '0;
                    for (int i = 0; i < N_RESP; i++) begin
                        vote_d[i] = '0;
                    end
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StSample: begin
                for (int i = 0; i < N_RESP; i++) begin
                    vote_d[i] = vote_q[i] + EW'(arb_raw[i]);
                end
                eval_d  = eval_q + 1'b1;
                state_d = StRelax;
            end
            StRelax: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    if (eval_q < EvalTotal) begin
                        state_d = StLaunch;
                    end else begin
                        for (int i = 0; i < N_RESP; i++) begin
                            response_d[i] = (vote_q[i] > EvalHalf);
                            unstable_d[i] = (vote_q[i] != '0) && (vote_q[i] != EvalTotal);
                        end
                        state_d = StDone;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered so the launch edge into the chains is glitch-free.
        pulse_d = (state_d == StLaunch) || (state_d == StSample);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            eval_q      <= '0;
            challenge_q <= '0;
            response_q  <= '0;
            unstable_q  <= '0;
            pulse       <= 1'b0;
            for (int i = 0; i < N_RESP; i++) begin
                vote_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            eval_q      <= eval_d;
            challenge_q <= challenge_d;
            response_q  <= response_d;
            unstable_q  <= unstable_d;
            pulse       <= pulse_d;
            vote_q      <= vote_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StDone);
    assign response   = response_q;
    assign unstable   = unstable_q;

endmodule

// File: tb/tb_arbiter_puf_tmv.sv
// Scoreboard bench for arbiter_puf_tmv: default build plus an N_EVAL=1, SETTLE_CYC=1 build.
module tb_arbiter_puf_tmv;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [15:0] challenge, response, unstable;
    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, busy1;
    logic [15:0] challenge1, response1, unstable1;

    int checks;
    int failures;

    logic [15:0] exp_resp_q[$];
    logic [15:0] exp_unst_q[$];
    logic [15:0] vset [7];
    logic [15:0] inj;
    logic [15:0] inj1;

    arbiter_puf_tmv dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .challenge  (challenge),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .response   (response),
        .unstable   (unstable),
        .busy       (busy)
    );

    arbiter_puf_tmv #(
        .N_STAGES   (16),
        .N_RESP     (16),
        .N_EVAL     (1),
        .SETTLE_CYC (1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .challenge  (challenge1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .response   (response1),
        .unstable   (unstable1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent majority / disagreement model over the seven injected words.
    task automatic model(input logic [15:0] v [7], output logic [15:0] r, output logic [15:0] u);
        for (int b = 0; b < 16; b++) begin
            int ones;
            ones = 0;
            for (int e = 0; e < 7; e++) ones += int'(v[e][b]);
            r[b] = (ones >= 4);
            u[b] = (ones != 0) && (ones != 7);
        end
    endtask

    task automatic run_txn(input logic [15:0] v [7], input int hold, input string name);
        logic [15:0] r, u, ch, er, eu;
        int  lat, hi, lo;
        bit  pulse_bad, hold_bad;
        model(v, r, u);
        exp_resp_q.push_back(r);
        exp_unst_q.push_back(u);
        ch         = 16'($urandom);
        challenge  = ch;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        inj        = v[0];
        force dut.arb_raw = inj;
        tick();
        req_valid = 1'b0;
        checks++;
        if (dut.challenge_q !== ch)
            begin failures++; $display("FAIL %s capture: got %h expected %h", name, dut.challenge_q, ch); end
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0)
            begin failures++; $display("FAIL %s accept: busy=%b req_ready=%b expected 1/0", name, busy, req_ready); end
        lat = 0; hi = 0; lo = 0; pulse_bad = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin
            if (dut.pulse === 1'b1) hi++; else lo++;
            if (lat % 9 == 8) begin
                if (hi != 5 || lo != 4) pulse_bad = 1;
                hi = 0; lo = 0;
            end
            tick();
            lat++;
            if (lat % 9 == 0 && lat < 63) begin
                inj = v[lat / 9];
                force dut.arb_raw = inj;
            end
        end
        checks++;
        if (lat != 63)
            begin failures++; $display("FAIL %s latency: got %0d expected 63", name, lat); end
        checks++;
        if (pulse_bad)
            begin failures++; $display("FAIL %s pulse: got bad high/low pattern expected 5 high 4 low", name); end
        er = exp_resp_q.pop_front();
        eu = exp_unst_q.pop_front();
        checks++;
        if (response !== er)
            begin failures++; $display("FAIL %s response: got %h expected %h", name, response, er); end
        checks++;
        if (unstable !== eu)
            begin failures++; $display("FAIL %s unstable: got %h expected %h", name, unstable, eu); end
        if (hold > 0) begin
            hold_bad = 0;
            for (int i = 0; i < hold; i++) begin
                req_valid = (i % 2 == 0);
                challenge = 16'($urandom);
                tick();
                if (resp_valid !== 1'b1 || response !== er || unstable !== eu ||
                    req_ready !== 1'b0 || dut.challenge_q !== ch) hold_bad = 1;
            end
            req_valid = 1'b0;
            checks++;
            if (hold_bad)
                begin failures++; $display("FAIL %s hold: got changed outputs expected stable %h/%h", name, er, eu); end
            resp_ready = 1'b1;
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
            begin failures++; $display("FAIL %s handshake: got rdy=%b busy=%b vld=%b expected 1/0/0", name, req_ready, busy, resp_valid); end
        release dut.arb_raw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
        checks++; if (response !== 16'h0) begin failures++; $display("FAIL reset response: got %h expected 0000", response); end
        checks++; if (unstable !== 16'h0) begin failures++; $display("FAIL reset unstable: got %h expected 0000", unstable); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
        checks++; if (dut.pulse !== 1'b0) begin failures++; $display("FAIL reset pulse: got %b expected 0", dut.pulse); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stable();
        foreach (vset[e]) vset[e] = 16'hA5A5;
        run_txn(vset, 0, "stable_a5a5");
    endtask

    task automatic test_split();
        foreach (vset[e]) vset[e] = (e < 4) ? 16'hFFFF : 16'h0000;
        run_txn(vset, 0, "split_4_3");
        foreach (vset[e]) vset[e] = (e < 3) ? 16'hFFFF : 16'h0000;
        run_txn(vset, 0, "split_3_4");
    endtask

    task automatic test_reset_mid();
        inj = 16'h1234;
        force dut.arb_raw = inj;
        challenge = 16'hBEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (29) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || dut.pulse !== 1'b0)
            begin failures++; $display("FAIL reset_mid ctrl: got rdy=%b busy=%b vld=%b pulse=%b expected 1/0/0/0", req_ready, busy, resp_valid, dut.pulse); end
        checks++;
        if (response !== 16'h0 || unstable !== 16'h0)
            begin failures++; $display("FAIL reset_mid data: got %h/%h expected 0000/0000", response, unstable); end
        #2 rst = 1'b0;
        release dut.arb_raw;
        tick();
        foreach (vset[e]) vset[e] = 16'h0F0F;
        run_txn(vset, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            foreach (vset[e]) vset[e] = 16'($urandom);
            run_txn(vset, 0, "random");
        end
    endtask

    task automatic test_hold();
        foreach (vset[e]) vset[e] = (e % 2 == 0) ? 16'hC3E1 : 16'h5A18;
        run_txn(vset, 20, "hold");
    endtask

    task automatic test_back_to_back();
        logic [15:0] c1, c2;
        int lat, k;
        bit seen_idle;
        inj = 16'h3C3C;
        force dut.arb_raw = inj;
        c1 = 16'($urandom);
        c2 = ~c1;
        challenge  = c1;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        tick();
        challenge = c2;
        checks++;
        if (dut.challenge_q !== c1) begin failures++; $display("FAIL b2b first capture: got %h expected %h", dut.challenge_q, c1); end
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
        checks++;
        if (lat != 63 || response !== 16'h3C3C)
            begin failures++; $display("FAIL b2b first resp: got lat=%0d resp=%h expected 63/3c3c", lat, response); end
        k = 0; seen_idle = 0;
        do begin
            tick(); k++;
            if (busy === 1'b0) seen_idle = 1;
        end while (!(seen_idle && busy === 1'b1) && k < 10);
        checks++;
        if (k != 2) begin failures++; $display("FAIL b2b reaccept: got %0d cycles expected 2", k); end
        checks++;
        if (dut.challenge_q !== c2) begin failures++; $display("FAIL b2b relatch: got %h expected %h", dut.challenge_q, c2); end
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
        checks++;
        if (lat != 63 || response !== 16'h3C3C || unstable !== 16'h0)
            begin failures++; $display("FAIL b2b second resp: got lat=%0d resp=%h unst=%h expected 63/3c3c/0000", lat, response, unstable); end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b idle: got %b expected 1", req_ready); end
        release dut.arb_raw;
    endtask

    task automatic test_n1();
        logic [15:0] vals [2];
        int lat;
        vals[0] = 16'h6D2B;
        vals[1] = 16'h92D4;
        for (int t = 0; t < 2; t++) begin
            inj1 = vals[t];
            force dut1.arb_raw = inj1;
            challenge1  = 16'($urandom);
            req_valid1  = 1'b1;
            resp_ready1 = 1'b1;
            tick();
            req_valid1 = 1'b0;
            lat = 0;
            while (resp_valid1 !== 1'b1 && lat < 50) begin tick(); lat++; end
            checks++;
            if (lat != 3) begin failures++; $display("FAIL n1 latency: got %0d expected 3", lat); end
            checks++;
            if (response1 !== vals[t]) begin failures++; $display("FAIL n1 response: got %h expected %h", response1, vals[t]); end
            checks++;
            if (unstable1 !== 16'h0) begin failures++; $display("FAIL n1 unstable: got %h expected 0000", unstable1); end
            tick();
            checks++;
            if (req_ready1 !== 1'b1) begin failures++; $display("FAIL n1 idle: got %b expected 1", req_ready1); end
            release dut1.arb_raw;
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        challenge   = '0;
        req_valid1  = 1'b0;
        resp_ready1 = 1'b0;
        challenge1  = '0;
        inj         = '0;
        inj1        = '0;
        test_reset();
        test_stable();
        test_split();
        test_reset_mid();
        test_random();
        test_hold();
        test_back_to_back();
        test_n1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/arbiter_puf_tmv.md
# arbiter_puf_tmv

Parametrised arbiter-PUF evaluation engine: N_RESP parallel arbiter delay chains of N_STAGES challenge-controlled stages, plus a sequencer that drives the launch pulse and evaluates each challenge N_EVAL times. A per-bit temporal majority vote (TMV) forms the response, and bits that disagreed across evaluations are flagged unstable. It replaces the free-running, pulse-driven 16×16 array, and sits between the challenge source and the key/ID post-processing logic behind valid/ready handshakes.

## Interface
- N_STAGES, 16, challenge width = stages per delay chain
- N_RESP, 16, response bits = number of parallel chains
- N_EVAL, 7, evaluations per challenge; odd, ≥1
- SETTLE_CYC, 4, clock cycles allowed for race resolution and for chain relaxation; ≥1
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  challenge offered
- req_ready  out  1  engine idle, challenge accepted when both high
- challenge  in  N_STAGES  challenge vector, captured on accept
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- response  out  N_RESP  majority-voted response
- unstable  out  N_RESP  bit i = 1 if chain i did not give the same value in all N_EVAL evaluations
- busy  out  1  high from accept until the response handshake

## Operation
- FSM states: IDLE, LAUNCH, SAMPLE, RELAX, DONE.
- IDLE: req_ready=1. On req_valid: latch challenge, clear all vote counters and eval_cnt, go to LAUNCH.
- LAUNCH: chain pulse=1 for SETTLE_CYC cycles, then SAMPLE.
- SAMPLE (1 cycle, pulse still 1): arb_raw[i] adds into vote_cnt[i]; eval_cnt++; go to RELAX.
- RELAX: pulse=0 for SETTLE_CYC cycles. Then go to LAUNCH if eval_cnt<N_EVAL, else to DONE.
- DONE: response[i] = (vote_cnt[i] > N_EVAL/2). unstable[i] = (vote_cnt[i]≠0 && vote_cnt[i]≠N_EVAL). Both are registered on entry to DONE. resp_valid=1 and is held stable until resp_ready; on the handshake go to IDLE.
- vote_cnt width $clog2(N_EVAL+1). eval_cnt uses the same width; no wrap is possible.
- The challenge register drives the chains and is stable for the whole evaluation. A req_valid asserted outside IDLE is ignored.
- N_EVAL=1: unstable is always 0.

## Timing
- Reset (async assert): state=IDLE, pulse=0, req_ready=1, resp_valid=0, response=0, unstable=0, busy=0, all counters 0.
- Reset mid-evaluation aborts immediately. There is no partial response, and the next request restarts from evaluation 0.
- Latency: resp_valid rises exactly N_EVAL·(2·SETTLE_CYC+1) cycles after the accept edge. With defaults this is 63.
- req_ready falls the cycle after accept. busy rises the cycle after accept.
- The response handshake edge returns the FSM to IDLE. req_ready=1 and busy=0 the following cycle, so the minimum request period is latency+2 cycles.
- resp_valid held with resp_ready=0: response and unstable are held indefinitely.

## Structure
- Shared package arbiter_puf_pkg holds the state enum and a localparam helper for counter width.
- One sub-module: arbiter_chain (parameter N_STAGES). It is the behavioural/placeable delay chain plus arbiter latch: inputs pulse and challenge, output one bit.
- The top instantiates N_RESP chains with a generate loop. Their outputs form internal net arb_raw[N_RESP-1:0]; the bench forces this net to inject per-evaluation values.
- Elaboration-time checks: N_EVAL odd, SETTLE_CYC≥1, N_STAGES≥1.

## Test plan
- Async reset mid-LAUNCH during evaluation 3: all outputs reach reset values without a clock. After release, the next request yields resp_valid exactly 63 cycles after accept.
- Force arb_raw=16'hA5A5 in all 7 evaluations: response=16'hA5A5, unstable=0, latency 63 cycles. Check pulse=1 for 5 cycles and 0 for 4 cycles in each evaluation.
- Force arb_raw=16'hFFFF for 4 evaluations and 16'h0000 for 3: response=16'hFFFF, unstable=16'hFFFF. Swap to 3/4: response=0.
- Hold resp_ready=0 for 20 cycles and toggle req_valid/challenge meanwhile: response is stable, req_ready=0, no new capture. Raising resp_ready completes the handshake and req_ready=1 the next cycle.
- Back-to-back requests with req_valid held high and resp_ready=1: second accept occurs 2 cycles after the first resp_valid, and challenge is re-latched.
- N_EVAL=1, SETTLE_CYC=1: latency 3 cycles, unstable=0, response equals the single arb_raw sample.
